// File: rtl/byte_pack_pkg.sv
// Shared widths and lane-counter type for the byte-to-word packer.
//   BYTE_W  : width of one input byte
//   WORD_W  : width of the assembled output word
//   LANES   : bytes per word
//   lane_t  : lane counter, L0 = next byte lands in bits 7:0
package byte_pack_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;

   typedef enum logic [1:0] {
      L0 = 2'd0,
      L1 = 2'd1,
      L2 = 2'd2,
      L3 = 2'd3
   } lane_t;

endpackage

// File: rtl/byte4_to_word32.sv
// Packs an 8-bit byte stream into 32-bit words, LSB first.
//   clock, reset    : rising-edge clock, async active-high reset
//   in_data/in_valid/in_sof/in_ready : byte input; in_sof marks byte 0 of a word
//   out_data/out_valid/out_ready     : word output with hold-while-stalled
//   err_align       : one-cycle pulse on a framing error
// Bytes for lanes 0-2 are staged; the 4th byte goes straight into the output
// register together with the staged bytes, so a word appears one cycle after
// its last byte is accepted.
module byte4_to_word32
   import byte_pack_pkg::*;
#(
   parameter bit REQUIRE_SOF = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [BYTE_W-1:0]   in_data,
   input  logic                in_valid,
   input  logic                in_sof,
   output logic                in_ready,
   output logic [WORD_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                err_align
);

   lane_t                          lane;
   logic [(LANES-1)*BYTE_W-1:0]    stage;

   logic acc;
   logic sof_err;
   logic drop_err;
   logic done;

   // Only the last lane needs output space; earlier lanes fill the staging
   // register, which keeps the stream moving with no bubbles between words.
   assign in_ready = (lane != L3) | ~out_valid | out_ready;
   assign acc      = in_valid & in_ready;

   // SOF in the middle of a word restarts the word with this byte as lane 0.
   assign sof_err  = acc & in_sof & (lane != L0);
   // Without SOF at lane 0 the byte is dropped when framing is mandatory.
   assign drop_err = acc & ~in_sof & (lane == L0) & REQUIRE_SOF;
   assign done     = acc & ~in_sof & (lane == L3);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lane      <= L0;
         stage     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         err_align <= 1'b0;
      end else begin
         err_align <= sof_err | drop_err;

         if (sof_err) begin
            stage <= {{(LANES-2)*BYTE_W{1'b0}}, in_data};
            lane  <= L1;
         end else if (acc && !drop_err) begin
            case (lane)
               L0: begin stage[7:0]   <= in_data; lane <= L1; end
               L1: begin stage[15:8]  <= in_data; lane <= L2; end
               L2: begin stage[23:16] <= in_data; lane <= L3; end
               L3: begin out_data     <= {in_data, stage}; lane <= L0; end
               default: lane <= L0;
            endcase
         end

         // A completing byte at L3 is only accepted when the register is free
         // or draining this cycle, so it takes priority over the drop.
         if (done)
            out_valid <= 1'b1;
         else if (out_valid && out_ready)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_byte4_to_word32.sv
module tb_byte4_to_word32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        err_align;

   // second instance with mandatory SOF framing
   logic [7:0]  r_data = '0;
   logic        r_valid = 1'b0;
   logic        r_sof = 1'b0;
   logic        r_in_ready;
   logic [31:0] r_out_data;
   logic        r_out_valid;
   logic        r_out_ready = 1'b1;
   logic        r_err;

   int checks = 0;
   int failures = 0;
   int err_cnt = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   byte4_to_word32 #(.REQUIRE_SOF(1'b0)) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_sof(in_sof), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .err_align(err_align));

   byte4_to_word32 #(.REQUIRE_SOF(1'b1)) dut_sof (
      .clock(clock), .reset(reset), .in_data(r_data), .in_valid(r_valid),
      .in_sof(r_sof), .in_ready(r_in_ready), .out_data(r_out_data),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .err_align(r_err));

   // scoreboard: every word transfer must match the oldest expected word
   always @(negedge clock) begin
      if (!reset) begin
         if (err_align) err_cnt++;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL word_unexpected: got %h, expected no word", out_data);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  failures++;
                  $display("FAIL word_data: got %h, expected %h", out_data, e);
               end
            end
         end
      end
   end

   // Starts at posedge+1; returns at posedge+1 just after the byte is accepted.
   task automatic send(input logic [7:0] b, input logic sof, output int waits);
      logic rdy;
      in_data = b; in_sof = sof; in_valid = 1'b1;
      waits = 0; rdy = 1'b0;
      while (!rdy && waits < 50) begin
         @(negedge clock);
         rdy = in_ready;
         @(posedge clock); #1;
         if (!rdy) waits++;
      end
      if (!rdy) begin
         checks++; failures++;
         $display("FAIL send_timeout: byte %h not accepted in 50 cycles", b);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data: got %h, expected 00000000", out_data); end
      checks++; if (err_align !== 1'b0) begin failures++; $display("FAIL rst_err: got %b, expected 0", err_align); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
      #2 reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready: got %b, expected 1", in_ready); end
      @(posedge clock); #1;
   endtask

   task automatic test_single();
      int w; int e0;
      e0 = err_cnt;
      out_ready = 1'b1;
      send(8'h11, 1'b1, w); send(8'h22, 1'b0, w); send(8'h33, 1'b0, w);
      exp_q.push_back(32'h44332211);
      send(8'h44, 1'b0, w);
      idle();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin
         failures++; $display("FAIL single_word: got v=%b %h, expected v=1 44332211", out_valid, out_data); end
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_one_cycle: got out_valid=%b, expected 0", out_valid); end
      checks++; if (err_cnt != e0) begin failures++; $display("FAIL single_err: got %0d pulses, expected 0", err_cnt - e0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[8];
      int w; int total;
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
      total = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) exp_q.push_back(32'hDDCCBBAA);
         if (i == 7) exp_q.push_back(32'h04030201);
         send(b[i], (i % 4) == 0, w);
         total += w;
         if (i == 4) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drop: got out_valid=%b, expected 0", out_valid); end
         end
      end
      idle();
      checks++; if (total != 0) begin failures++; $display("FAIL b2b_bubbles: got %0d stall cycles, expected 0", total); end
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
         failures++; $display("FAIL b2b_second: got v=%b %h, expected v=1 04030201", out_valid, out_data); end
      @(posedge clock); #1;
   endtask

   task automatic test_backpressure();
      int w; int total;
      out_ready = 1'b0;
      send(8'h11, 1'b1, w); send(8'h22, 1'b0, w); send(8'h33, 1'b0, w);
      exp_q.push_back(32'h44332211);
      send(8'h44, 1'b0, w);
      idle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++; if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin
            failures++; $display("FAIL bp_hold%0d: got v=%b %h, expected v=1 44332211", i, out_valid, out_data); end
         @(posedge clock); #1;
      end
      total = 0;
      send(8'h55, 1'b1, w); total += w;
      send(8'h66, 1'b0, w); total += w;
      send(8'h77, 1'b0, w); total += w;
      checks++; if (total != 0) begin failures++; $display("FAIL bp_lanes_ready: got %0d stall cycles, expected 0", total); end
      in_data = 8'h88; in_sof = 1'b0; in_valid = 1'b1;
      exp_q.push_back(32'h88776655);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d: got %b, expected 0", i, in_ready); end
         checks++; if (out_data !== 32'h44332211 || out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold_l3_%0d: got v=%b %h, expected v=1 44332211", i, out_valid, out_data); end
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      send(8'h88, 1'b0, w);
      idle();
      checks++; if (w != 0) begin failures++; $display("FAIL bp_release: got %0d waits, expected 0", w); end
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h88776655) begin
         failures++; $display("FAIL bp_second: got v=%b %h, expected v=1 88776655", out_valid, out_data); end
      @(posedge clock); #1;
   endtask

   task automatic test_realign();
      int w; int e0;
      out_ready = 1'b1;
      e0 = err_cnt;
      send(8'h11, 1'b1, w); send(8'h22, 1'b0, w);
      send(8'h99, 1'b1, w);
      checks++; if (err_align !== 1'b1) begin failures++; $display("FAIL realign_pulse: got %b, expected 1", err_align); end
      send(8'h98, 1'b0, w);
      checks++; if (err_align !== 1'b0) begin failures++; $display("FAIL realign_clear: got %b, expected 0", err_align); end
      send(8'h97, 1'b0, w);
      exp_q.push_back(32'h96979899);
      send(8'h96, 1'b0, w);
      // SOF on the 4th byte aborts the word and restarts it
      send(8'h01, 1'b1, w); send(8'h02, 1'b0, w); send(8'h03, 1'b0, w);
      send(8'h04, 1'b1, w);
      checks++; if (out_valid !== 1'b0 || err_align !== 1'b1) begin
         failures++; $display("FAIL abort_4th: got v=%b err=%b, expected v=0 err=1", out_valid, err_align); end
      send(8'h05, 1'b0, w); send(8'h06, 1'b0, w);
      exp_q.push_back(32'h07060504);
      send(8'h07, 1'b0, w);
      idle();
      @(posedge clock); #1;
      checks++; if (err_cnt - e0 != 2) begin failures++; $display("FAIL realign_count: got %0d pulses, expected 2", err_cnt - e0); end
   endtask

   task automatic test_no_sof();
      int w; int e0;
      e0 = err_cnt;
      out_ready = 1'b1;
      send(8'hC1, 1'b0, w); send(8'hC2, 1'b0, w); send(8'hC3, 1'b0, w);
      exp_q.push_back(32'hC4C3C2C1);
      send(8'hC4, 1'b0, w);
      idle();
      @(posedge clock); #1;
      checks++; if (err_cnt != e0) begin failures++; $display("FAIL no_sof_err: got %0d pulses, expected 0", err_cnt - e0); end
   endtask

   task automatic test_require_sof();
      logic [7:0] b[4];
      b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      r_data = 8'h5A; r_sof = 1'b0; r_valid = 1'b1;
      @(posedge clock); #1;
      checks++; if (r_err !== 1'b1 || r_out_valid !== 1'b0) begin
         failures++; $display("FAIL rsof_drop: got err=%b v=%b, expected err=1 v=0", r_err, r_out_valid); end
      for (int i = 0; i < 4; i++) begin
         r_data = b[i]; r_sof = (i == 0);
         @(posedge clock); #1;
         if (i == 0) begin
            checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL rsof_lane0: got err=%b, expected 0", r_err); end
         end
      end
      r_valid = 1'b0; r_sof = 1'b0;
      checks++; if (r_out_valid !== 1'b1 || r_out_data !== 32'hD4C3B2A1) begin
         failures++; $display("FAIL rsof_word: got v=%b %h, expected v=1 D4C3B2A1", r_out_valid, r_out_data); end
      @(posedge clock); #1;
   endtask

   task automatic test_reset_mid();
      int w; int e0;
      out_ready = 1'b0;
      send(8'h11, 1'b1, w); send(8'h22, 1'b0, w); send(8'h33, 1'b0, w);
      exp_q.push_back(32'h44332211);
      send(8'h44, 1'b0, w);
      send(8'h55, 1'b1, w); send(8'h66, 1'b0, w); send(8'h77, 1'b0, w);
      idle();
      #2 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
         failures++; $display("FAIL mid_rst_out: got v=%b %h, expected v=0 00000000", out_valid, out_data); end
      checks++; if (in_ready !== 1'b1 || err_align !== 1'b0) begin
         failures++; $display("FAIL mid_rst_flags: got rdy=%b err=%b, expected rdy=1 err=0", in_ready, err_align); end
      exp_q.delete();
      e0 = err_cnt;
      @(posedge clock); #3 reset = 1'b0;
      @(posedge clock); #1;
      out_ready = 1'b1;
      // no SOF: the word is only correct if the lane really returned to L0
      send(8'hE1, 1'b0, w); send(8'hE2, 1'b0, w); send(8'hE3, 1'b0, w);
      exp_q.push_back(32'hE4E3E2E1);
      send(8'hE4, 1'b0, w);
      idle();
      @(posedge clock); #1;
      checks++; if (err_cnt != e0) begin failures++; $display("FAIL mid_rst_err: got %0d pulses, expected 0", err_cnt - e0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_realign();
      test_no_sof();
      test_require_sof();
      test_reset_mid();
      repeat (3) @(posedge clock);
      #1;
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL words_missing: got %0d undelivered, expected 0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/byte4_to_word32.md
BYTE4_TO_WORD32 -- requirements
Module: byte4_to_word32

Interface
REQ-001 Parameter REQUIRE_SOF, default 0, meaning: 1 = drop bytes that arrive at lane 0 without in_sof; 0 = any byte may start a word.
REQ-002 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  8  byte stream.
REQ-005 in_valid  input  1  in_data qualifier.
REQ-006 in_sof  input  1  marks the byte as byte 0 (bits 7:0) of a word.
REQ-007 in_ready  output  1  block can accept a byte this cycle.
REQ-008 out_data  output  32  assembled word.
REQ-009 out_valid  output  1  out_data qualifier.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 err_align  output  1  one-cycle pulse on any framing error.

Function
REQ-012 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-013 Byte order SHALL be LSB-first: 1st byte -> out_data[7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-014 A 2-bit lane counter SHALL take values L0, L1, L2, L3. It SHALL advance L0->L1->L2->L3 on each accepted byte and wrap to L0 when the 4th byte is accepted.
REQ-015 Accepted bytes SHALL be staged in an internal 24-bit register for lanes 0-2. The 4th byte SHALL be combined with the staged bytes directly into out_data.
REQ-016 out_valid SHALL rise on the clock edge that accepts the 4th byte; latency from 4th-byte acceptance to out_valid is 1 cycle.
REQ-017 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 Word transfer SHALL occur when out_valid and out_ready are both 1. out_valid SHALL then drop unless a new 4th byte is accepted in the same cycle.
REQ-019 in_ready SHALL be 1 at lanes L0-L2 regardless of output state.
REQ-020 At L3, in_ready SHALL equal (!out_valid | out_ready), giving back-to-back words with zero bubbles.
REQ-021 in_ready SHALL be combinational from state and out_ready; there SHALL be no combinational path from in_valid to in_ready.
REQ-022 Accepted byte with in_sof=1 at lanes L1-L3:
- partial word discarded;
- err_align pulses for 1 cycle;
- byte stored as lane 0; counter -> L1.
REQ-023 Accepted byte with in_sof=0 at L0 and REQUIRE_SOF=1:
- byte dropped; counter stays L0;
- err_align pulses for 1 cycle.
REQ-024 With REQUIRE_SOF=0, a byte with in_sof=0 at L0 SHALL be accepted as lane 0 without error.
REQ-025 in_sof on the 4th byte of a word SHALL follow REQ-022, not complete the word. No output SHALL be produced for an aborted word.
REQ-026 err_align SHALL be registered and SHALL be 0 in every cycle without a new error.

Reset
REQ-027 During reset the following SHALL be forced:
- lane counter L0; staging register 0;
- out_data 32'h0; out_valid 0; err_align 0.
REQ-028 in_ready SHALL read 1 during and immediately after reset.
REQ-029 Reset asserted mid-word SHALL discard all partial bytes and any pending unaccepted word, with no err_align pulse.

Structure
REQ-030 Package byte_pack_pkg SHALL hold BYTE_W=8, WORD_W=32, LANES=4 and the lane-counter enum type (L0..L3).
REQ-031 The block SHALL be a single module with no sub-module. The output holding register SHALL be inline, not a separate FIFO.

Verification
REQ-032 Bytes 11,22,33,44 (in_sof on 11), out_ready=1 -> out_data=32'h44332211, out_valid high exactly 1 cycle, 1 cycle after byte 44 accepted.
REQ-033 Two words back-to-back (AA,BB,CC,DD / 01,02,03,04), in_valid continuous, out_ready=1 -> 32'hDDCCBBAA then 32'h04030201, in_ready never low, no bubbles.
REQ-034 Word 32'h44332211 complete, out_ready=0 for 5 cycles, next bytes 55,66,77 sent, then 88 offered -> in_ready=0 at L3 until out_ready=1.
- First word held unchanged throughout.
- Second word = 32'h88776655.
REQ-035 Bytes 11,22 then 99 with in_sof, then 98,97,96 -> err_align pulses once on the 99 edge; out_data=32'h96979899; 11/22 never appear.
REQ-036 REQUIRE_SOF=1, byte 5A without in_sof at L0 -> dropped, err_align pulse, lane stays L0; following 4-byte SOF word assembles correctly.
REQ-037 Reset pulsed after 3 bytes, with out_valid=1 and out_ready=0 -> out_valid=0 and lane L0 immediately (async); next 4 bytes form a clean word.
